multi_cycle_ctrl: RTL and testbench

- Next-generation control unit for the multi-cycle MIPS datapath; successor to the single-cycle R-type decoder.
- Moore FSM (one Mealy term, the branch condition) sequencing FETCH/DECODE/EXECUTE/MEM/WB and driving all datapath enables and muxes.
- Adds I-type, load/store, branch and jump support, a parametrised ALU-op width, defined defaults in every state (no latches), and illegal-instruction detection.

---
 rtl/multi_cycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS control FSM (R/I-type, lw/sw, beq, j); define ILLEGAL_TRAP_EN to trap on illegal instructions.
module multi_cycle_ctrl #(
  parameter int ALUOP_W = 5,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic               trap,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5,
    R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11, TRAP = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
  localparam logic [ALUOP_W-1:0] A_ADDU = ALUOP_W'(3'd1), A_SUBU = ALUOP_W'(3'd2), A_OR = ALUOP_W'(3'd4);
  state_t cur, nxt;
  logic r_ok, dec_ill;
  logic [2:0] r_op;
  always_comb begin
    r_ok = 1'b1;
    r_op = 3'd1;
    case (funct)
      6'b100000: r_op = 3'd0;
      6'b100001: r_op = 3'd1;
      6'b100011: r_op = 3'd2;
      6'b100100: r_op = 3'd3;
      6'b100101: r_op = 3'd4;
      6'b101010: r_op = 3'd5;
      default:   r_ok = 1'b0;
    endcase
  end
  assign dec_ill = !((op == OP_R && r_ok) || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                     op == OP_J || op == OP_ADDIU || op == OP_ORI);
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = DECODE;
      DECODE:   nxt = (op == OP_R && r_ok)                ? R_EXEC   :
                      (op == OP_LW || op == OP_SW)        ? MEM_ADDR :
                      (op == OP_BEQ)                      ? BRANCH   :
                      (op == OP_J)                        ? JUMP     :
                      (op == OP_ADDIU || op == OP_ORI)    ? I_EXEC   :
`ifdef ILLEGAL_TRAP_EN
                                                            TRAP;
`else
                                                            FETCH;
`endif
      MEM_ADDR: nxt = (op == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = MEM_WB;
      R_EXEC:   nxt = R_WB;
      I_EXEC:   nxt = I_WB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     nxt = TRAP;
`endif
      default:  nxt = FETCH;
    endcase
  end
  // Outputs are forced to defaults while rst is high so an aborted write never lands.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    aluop      = A_ADDU;
    illegal    = 1'b0;
    trap       = 1'b0;
    if (!rst)
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          illegal   = dec_ill;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_W'(r_op);
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: mem_read = 1'b1;
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: mem_write = 1'b1;
        BRANCH: begin
          alu_src_a = 1'b1;
          aluop     = A_SUBU;
          pc_src    = 2'b01;
          pc_write  = zero;
        end
        JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          imm_zext  = (op == OP_ORI);
          aluop     = (op == OP_ORI) ? A_OR : A_ADDU;
        end
        I_WB: begin
          reg_write = 1'b1;
          imm_zext  = (op == OP_ORI);
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: trap = 1'b1;
`endif
        default: ;
      endcase
  end
  assign state = STATE_W'(cur);
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench; instruction-level model queues expected per-cycle control words.
module tb_multi_cycle_ctrl;
  logic clk = 0, rst = 1, zero = 0;
  logic [5:0] op = 0, funct = 0;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext, illegal, trap;
  logic [1:0] alu_src_b, pc_src;
  logic [4:0] aluop;
  logic [3:0] state;
  int tests = 0, fails = 0;
  bit en = 0;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, mr, mw, rw, rd, m2r, asa;
    logic [1:0] asb;
    logic iz;
    logic [1:0] ps;
    logic [4:0] aop;
    logic ill, trp;
  } rec_t;
  rec_t exp_q[$];
  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
    .pc_src(pc_src), .aluop(aluop), .illegal(illegal), .trap(trap), .state(state));
  always #5 clk = ~clk;
  function automatic rec_t dflt(input logic [3:0] s);
    rec_t r = '0;
    r.st = s;
    r.aop = 5'd1;
    return r;
  endfunction
  function automatic rec_t act();
    return {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
            alu_src_b, imm_zext, pc_src, aluop, illegal, trap};
  endfunction
  task automatic check(input string name, input rec_t got, input rec_t want);
    tests++;
    if (got !== want || (got.pcw && got.mw)) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask
  // Monitor: reset cycles must show defaults; otherwise every cycle consumes one expected word.
  always @(negedge clk) begin
    if (rst) check("reset", act(), dflt(4'd0));
    else if (en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL underflow: DUT cycle with no expected word, state %0d", state);
      end else check("cycle", act(), exp_q.pop_front());
    end
  end
  // Instruction-level model: derive the control-word sequence straight from the opcode class.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    rec_t r;
    int n;
    logic r_ok;
    logic [4:0] r_aop;
    r_ok = (o == 6'd0) && (f inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd42});
    r_aop = (f == 6'd32) ? 5'd0 : (f == 6'd33) ? 5'd1 : (f == 6'd35) ? 5'd2 :
            (f == 6'd36) ? 5'd3 : (f == 6'd37) ? 5'd4 : 5'd5;
    op = o; funct = f; zero = z;
    r = dflt(4'd0); r.pcw = 1; r.irw = 1; r.mr = 1; r.asb = 2'b01; exp_q.push_back(r);
    r = dflt(4'd1); r.asb = 2'b11;
    r.ill = !(r_ok || o inside {6'd35, 6'd43, 6'd4, 6'd2, 6'd9, 6'd13});
    exp_q.push_back(r);
    if (r_ok) begin
      r = dflt(4'd6); r.asa = 1; r.aop = r_aop; exp_q.push_back(r);
      r = dflt(4'd7); r.rw = 1; r.rd = 1; exp_q.push_back(r);
      n = 4;
    end else if (o == 6'd35 || o == 6'd43) begin
      r = dflt(4'd2); r.asa = 1; r.asb = 2'b10; exp_q.push_back(r);
      if (o == 6'd35) begin
        r = dflt(4'd3); r.mr = 1; exp_q.push_back(r);
        r = dflt(4'd4); r.rw = 1; r.m2r = 1; exp_q.push_back(r);
        n = 5;
      end else begin
        r = dflt(4'd5); r.mw = 1; exp_q.push_back(r);
        n = 4;
      end
    end else if (o == 6'd4) begin
      r = dflt(4'd8); r.asa = 1; r.aop = 5'd2; r.ps = 2'b01; r.pcw = z; exp_q.push_back(r);
      n = 3;
    end else if (o == 6'd2) begin
      r = dflt(4'd9); r.ps = 2'b10; r.pcw = 1; exp_q.push_back(r);
      n = 3;
    end else if (o == 6'd9 || o == 6'd13) begin
      r = dflt(4'd10); r.asa = 1; r.asb = 2'b10; r.iz = (o == 6'd13); r.aop = (o == 6'd13) ? 5'd4 : 5'd1;
      exp_q.push_back(r);
      r = dflt(4'd11); r.rw = 1; r.iz = (o == 6'd13); exp_q.push_back(r);
      n = 4;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      r = dflt(4'd12); r.trp = 1;
      repeat (3) exp_q.push_back(r);
      n = 5;
`else
      n = 2;
`endif
    end
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    en = 0;
    exp_q.delete();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    en = 1;
  endtask
  task automatic rand_instr();
    logic [5:0] o, f;
    int k;
`ifdef ILLEGAL_TRAP_EN
    k = $urandom_range(0, 11);
`else
    k = $urandom_range(0, 13);
`endif
    f = 6'($urandom);
    case (k)
      0, 1, 2, 3, 4, 5: begin
        o = 6'd0;
        f = (k == 0) ? 6'd32 : (k == 1) ? 6'd33 : (k == 2) ? 6'd35 : (k == 3) ? 6'd36 : (k == 4) ? 6'd37 : 6'd42;
      end
      6: o = 6'd35;
      7: o = 6'd43;
      8: o = 6'd4;
      9: o = 6'd2;
      10: o = 6'd9;
      11: o = 6'd13;
      12: begin
        o = 6'd0;
        while (f inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd42}) f = 6'($urandom);
      end
      default: begin
        o = 6'($urandom);
        while (o inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd9, 6'd13}) o = 6'($urandom);
      end
    endcase
    issue(o, f, 1'($urandom));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    issue(6'd0, 6'b100000, 0);
    issue(6'd35, 6'd0, 0);
    issue(6'd43, 6'd0, 0);
    issue(6'd4, 6'd0, 1);
    issue(6'd4, 6'd0, 0);
    issue(6'd2, 6'd0, 0);
    issue(6'd13, 6'd0, 0);
`ifndef ILLEGAL_TRAP_EN
    issue(6'b111111, 6'd0, 0);
`endif
    // lw interrupted by reset while in MEM_WB: outputs must clear at once.
    op = 6'd35; funct = 0;
    begin
      rec_t r;
      r = dflt(4'd0); r.pcw = 1; r.irw = 1; r.mr = 1; r.asb = 2'b01; exp_q.push_back(r);
      r = dflt(4'd1); r.asb = 2'b11; exp_q.push_back(r);
      r = dflt(4'd2); r.asa = 1; r.asb = 2'b10; exp_q.push_back(r);
      r = dflt(4'd3); r.mr = 1; exp_q.push_back(r);
    end
    repeat (4) @(posedge clk);
    #1 rst = 1;
    en = 0;
    #1 check("async_reset", act(), dflt(4'd0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    en = 1;
    repeat (250) rand_instr();
`ifdef ILLEGAL_TRAP_EN
    issue(6'b111111, 6'd0, 0);
    do_reset();
    issue(6'd0, 6'b100001, 0);
`endif
    en = 0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
